// File: rtl/ttr_pkg.sv
// Shared types and helpers for the truth-table recorder.
// Holds the sweep FSM state encoding and the row-width helper.
package ttr_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2,
        FIN   = 2'd3
    } ttr_state_e;

    // A table row is the stimulus vector followed by the single response bit.
    function automatic int row_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/ttr_table.sv
// Small register file: one synchronous write port, one asynchronous read
// port, and an asynchronous clear on reset.
module ttr_table #(
    parameter int AW = 3,
    parameter int W  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0] mem_q [DEPTH];

    // Storage: cleared on reset, written one row per cycle when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/truth_table_recorder.sv
// Hardware truth-table writer. Sweeps every input combination of an external
// combinational block, waits SETTLE cycles, captures {stim, resp} into an
// internal table and streams each row out.
// Optional self-check hardware is compiled in with the TTR_CHECK_EN macro.
//
// Row stream handshake: row_data is meaningful only while row_valid is high;
// a row transfers on a rising edge where row_valid and row_ready are both
// high. Once raised, row_valid stays high and row_data stays stable until
// that transfer happens.
module truth_table_recorder
    import ttr_pkg::*;
#(
    parameter  int N_IN   = 3,
    parameter  int SETTLE = 1,
    localparam int W      = row_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            resp,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [W-1:0]    row_data,
    output logic            busy,
    output logic            done,
    input  logic [N_IN-1:0] rd_addr,
    output logic [W-1:0]    rd_data
`ifdef TTR_CHECK_EN
    ,
    input  logic            exp_we,
    input  logic [N_IN-1:0] exp_addr,
    input  logic            exp_d,
    output logic [N_IN:0]   pass_cnt,
    output logic            mismatch
`endif
);

    localparam int              ROWS        = 2 ** N_IN;
    localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(ROWS - 1);
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

    ttr_state_e      state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic            row_valid_q, row_valid_d;
    logic [W-1:0]    row_data_q, row_data_d;
    logic            capture;
    logic            sweep_go;

    // Sweep control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            stim_q      <= '0;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            stim_q      <= stim_d;
            row_valid_q <= row_valid_d;
            row_data_q  <= row_data_d;
        end
    end

    // Next-state logic: drive a row, wait for it to settle, capture, hand off.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        stim_d      = stim_q;
        row_valid_d = row_valid_q;
        row_data_d  = row_data_q;
        capture     = 1'b0;
        sweep_go    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sweep_go = 1'b1;
                    state_d  = DRIVE;
                    idx_d    = '0;
                    stim_d   = '0;
                    cnt_d    = SETTLE_LOAD;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    // resp has been stable for SETTLE cycles; take the row.
                    capture     = 1'b1;
                    row_data_d  = {idx_q, resp};
                    row_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (row_valid_q && row_ready) begin
                    row_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = FIN;
                        stim_d  = '0;
                    end else begin
                        idx_d   = idx_q + N_IN'(1);
                        stim_d  = idx_q + N_IN'(1);
                        cnt_d   = SETTLE_LOAD;
                        state_d = DRIVE;
                    end
                end
            end
            FIN: begin
                stim_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stim      = stim_q;
    assign row_valid = row_valid_q;
    assign row_data  = row_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);

    ttr_table #(.AW(N_IN), .W(W)) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (capture),
        .waddr (idx_q),
        .wdata ({idx_q, resp}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

`ifdef TTR_CHECK_EN
    logic          exp_bit;
    logic [N_IN:0] pass_cnt_q, pass_cnt_d;
    logic          mismatch_q, mismatch_d;

    // Expected responses may only be loaded while no sweep is running.
    ttr_table #(.AW(N_IN), .W(1)) u_exp_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (exp_we && (state_q == IDLE)),
        .waddr (exp_addr),
        .wdata (exp_d),
        .raddr (idx_q),
        .rdata (exp_bit)
    );

    // Score each captured row against the expected table.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        mismatch_d = mismatch_q;
        if (sweep_go) begin
            pass_cnt_d = '0;
            mismatch_d = 1'b0;
        end else if (capture) begin
            if (resp == exp_bit) begin
                pass_cnt_d = pass_cnt_q + (N_IN + 1)'(1);
            end else begin
                mismatch_d = 1'b1;
            end
        end
    end

    // Check result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign mismatch = mismatch_q;
`endif

endmodule
